// File: rtl/urp_pcie_dll_pkg.sv
// Shared data link layer definitions: DLLP types, frame layout and the LCRC.
package urp_pcie_dll_pkg;

    localparam int SEQ_W    = 12;
    localparam int TLP_W    = 224;
    localparam int LCRC_W   = 32;
    localparam int FRAME_W  = SEQ_W + TLP_W + LCRC_W;
    localparam int CRC_IN_W = SEQ_W + TLP_W;

    // Frame field offsets: [267:256] seq, [255:32] TLP, [31:0] LCRC.
    localparam int SEQ_LSB  = TLP_W + LCRC_W;
    localparam int TLP_LSB  = LCRC_W;
    localparam int LCRC_LSB = 0;

    localparam logic [7:0]  DLLP_ACK  = 8'h00;
    localparam logic [7:0]  DLLP_NAK  = 8'h10;
    localparam logic [31:0] LCRC_POLY = 32'h04C11DB7;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_REPLAY = 1'b1
    } dll_state_e;

    // CRC-32 over the sequence number and TLP, MSB first, init all ones, inverted result.
    function automatic logic [LCRC_W-1:0] crc32_lcrc(input logic [CRC_IN_W-1:0] data);
        logic [LCRC_W-1:0] crc;
        logic [LCRC_W-1:0] shifted;
        logic              fb;
        crc = 32'hFFFF_FFFF;
        for (int i = CRC_IN_W - 1; i >= 0; i--) begin
            fb      = crc[31] ^ data[i];
            shifted = {crc[30:0], 1'b0};
            crc     = fb ? (shifted ^ LCRC_POLY) : shifted;
        end
        return ~crc;
    endfunction

endpackage

// File: rtl/urp_pcie_tx_data_link_layer_if.sv
// TLP input, frame output and DLLP input of the transmit data link layer.
interface urp_pcie_tx_data_link_layer_if;
    import urp_pcie_dll_pkg::*;

    logic [TLP_W-1:0]   tlp_data_i;
    logic               tlp_data_valid_i;
    logic               tlp_data_ready_o;
    logic [FRAME_W-1:0] tx_tlp_data_o;
    logic               tx_tlp_valid_o;
    logic               tx_tlp_ready_i;
    logic [31:0]        dllp_i;
    logic               dllp_valid_i;
    logic               dllp_ready_o;
    logic               replay_active_o;

    modport master (
        output tlp_data_i, tlp_data_valid_i, tx_tlp_ready_i, dllp_i, dllp_valid_i,
        input  tlp_data_ready_o, tx_tlp_data_o, tx_tlp_valid_o, dllp_ready_o, replay_active_o
    );

    modport slave (
        input  tlp_data_i, tlp_data_valid_i, tx_tlp_ready_i, dllp_i, dllp_valid_i,
        output tlp_data_ready_o, tx_tlp_data_o, tx_tlp_valid_o, dllp_ready_o, replay_active_o
    );

endinterface

// File: rtl/urp_pcie_replay_buffer.sv
// Replay storage for unacknowledged TLPs: registered write, combinational read.
module urp_pcie_replay_buffer
    import urp_pcie_dll_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [TLP_W-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [TLP_W-1:0] rd_data
);

    logic [TLP_W-1:0] mem_r [DEPTH];

    // Store each accepted TLP at the slot selected by its sequence number.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/urp_pcie_tx_data_link_layer.sv
// Transmit data link layer: sequence numbering, LCRC, replay buffer and ACK/NAK handling.
module urp_pcie_tx_data_link_layer
    import urp_pcie_dll_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    urp_pcie_tx_data_link_layer_if.slave bus
);

    localparam int                 AW           = $clog2(DEPTH);
    localparam int                 TIMER_W      = $clog2(REPLAY_TIMEOUT) + 1;
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(REPLAY_TIMEOUT - 1);
    localparam logic [SEQ_W-1:0]   DEPTH_SEQ    = SEQ_W'(DEPTH);

    dll_state_e         state_r, state_nxt_s;
    logic [SEQ_W-1:0]   next_seq_r, acked_seq_r, rp_r, rp_nxt_s;
    logic [TIMER_W-1:0] timer_r;
    logic               out_valid_r, run_r;
    logic [FRAME_W-1:0] out_data_r;

    logic [SEQ_W-1:0]   occupancy_s, occ_after_s, ack_dist_s, acked_nxt_s, dllp_seq_s;
    logic [SEQ_W-1:0]   rp_adv_s, rp_replay_s, frame_seq_s;
    logic [TLP_W-1:0]   frame_tlp_s, rd_data_s;
    logic [7:0]         dllp_type_s;
    logic               out_free_s, is_ack_s, is_nak_s, ack_ok_s, ack_jump_s;
    logic               tlp_ready_s, accept_s, replay_send_s, timeout_s, load_s;
    logic               unused_dllp_bits_s;

    assign dllp_type_s        = bus.dllp_i[31:24];
    assign dllp_seq_s         = bus.dllp_i[SEQ_W-1:0];
    assign unused_dllp_bits_s = ^bus.dllp_i[23:SEQ_W];

    // Entries sent but not yet acknowledged; modulo arithmetic handles the 4095 -> 0 wrap.
    assign occupancy_s = next_seq_r - acked_seq_r - 12'd1;
    assign out_free_s  = !out_valid_r || bus.tx_tlp_ready_i;

    // An ACK/NAK sequence is honoured only if it lands inside the outstanding window.
    assign is_ack_s    = run_r && bus.dllp_valid_i && (dllp_type_s == DLLP_ACK);
    assign is_nak_s    = run_r && bus.dllp_valid_i && (dllp_type_s == DLLP_NAK);
    assign ack_dist_s  = dllp_seq_s - acked_seq_r;
    assign ack_ok_s    = (is_ack_s || is_nak_s) && (ack_dist_s != 12'd0) && (ack_dist_s <= occupancy_s);
    assign acked_nxt_s = ack_ok_s ? dllp_seq_s : acked_seq_r;
    assign occ_after_s = next_seq_r - acked_nxt_s - 12'd1;

    assign accept_s      = tlp_ready_s && bus.tlp_data_valid_i;
    assign replay_send_s = (state_r == ST_REPLAY) && (rp_r != next_seq_r) && out_free_s;
    assign load_s        = accept_s || replay_send_s;
    assign timeout_s     = (state_r == ST_NORMAL) && (occupancy_s != 12'd0) &&
                           (timer_r == TIMEOUT_LAST) && !ack_ok_s && !is_nak_s;

    // A purge during replay pulls the replay pointer forward past newly acknowledged entries.
    assign rp_adv_s    = replay_send_s ? (rp_r + 12'd1) : rp_r;
    assign ack_jump_s  = ack_ok_s && ((ack_dist_s + 12'd1) > (rp_adv_s - acked_seq_r));
    assign rp_replay_s = ack_jump_s ? (dllp_seq_s + 12'd1) : rp_adv_s;

    urp_pcie_replay_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_replay_buffer (
        .clk     (clk),
        .wr_en   (accept_s),
        .wr_addr (next_seq_r[AW-1:0]),
        .wr_data (bus.tlp_data_i),
        .rd_addr (rp_r[AW-1:0]),
        .rd_data (rd_data_s)
    );

    // FSM state register together with the replay pointer it steers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_NORMAL;
            rp_r    <= 12'd0;
        end else begin
            state_r <= state_nxt_s;
            rp_r    <= rp_nxt_s;
        end
    end

    // FSM next state: NAK or timeout starts a replay; replay ends after the newest entry is loaded.
    always_comb begin
        state_nxt_s = state_r;
        rp_nxt_s    = rp_r;
        case (state_r)
            ST_NORMAL: begin
                if (is_nak_s) begin
                    rp_nxt_s    = acked_nxt_s + 12'd1;
                    state_nxt_s = (occ_after_s != 12'd0) ? ST_REPLAY : ST_NORMAL;
                end else if (timeout_s) begin
                    rp_nxt_s    = acked_seq_r + 12'd1;
                    state_nxt_s = ST_REPLAY;
                end else begin
                    rp_nxt_s    = rp_r;
                    state_nxt_s = ST_NORMAL;
                end
            end
            ST_REPLAY: begin
                if (is_nak_s) begin
                    rp_nxt_s    = acked_nxt_s + 12'd1;
                    state_nxt_s = (occ_after_s != 12'd0) ? ST_REPLAY : ST_NORMAL;
                end else begin
                    rp_nxt_s    = rp_replay_s;
                    state_nxt_s = (rp_replay_s == next_seq_r) ? ST_NORMAL : ST_REPLAY;
                end
            end
            default: begin
                rp_nxt_s    = rp_r;
                state_nxt_s = ST_NORMAL;
            end
        endcase
    end

    // FSM outputs: frame source is the live TLP in NORMAL and the replay buffer in REPLAY.
    always_comb begin
        frame_seq_s = next_seq_r;
        frame_tlp_s = bus.tlp_data_i;
        tlp_ready_s = 1'b0;
        case (state_r)
            ST_NORMAL: begin
                frame_seq_s = next_seq_r;
                frame_tlp_s = bus.tlp_data_i;
                tlp_ready_s = run_r && (occupancy_s < DEPTH_SEQ) && out_free_s;
            end
            ST_REPLAY: begin
                frame_seq_s = rp_r;
                frame_tlp_s = rd_data_s;
                tlp_ready_s = 1'b0;
            end
            default: begin
                frame_seq_s = next_seq_r;
                frame_tlp_s = bus.tlp_data_i;
                tlp_ready_s = 1'b0;
            end
        endcase
    end

    // Sequence bookkeeping: allocate on accept, retire on a valid ACK/NAK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_seq_r  <= 12'd0;
            acked_seq_r <= 12'hFFF;
        end else begin
            next_seq_r  <= accept_s ? (next_seq_r + 12'd1) : next_seq_r;
            acked_seq_r <= acked_nxt_s;
        end
    end

    // Replay timer measures cycles without forward progress while entries are outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= {TIMER_W{1'b0}};
        end else if ((state_r == ST_REPLAY) || (occupancy_s == 12'd0) || ack_ok_s || is_nak_s || timeout_s) begin
            timer_r <= {TIMER_W{1'b0}};
        end else begin
            timer_r <= timer_r + TIMER_W'(1);
        end
    end

    // Output frame register: holds the frame stable until the link takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {FRAME_W{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= {frame_seq_s, frame_tlp_s, crc32_lcrc({frame_seq_s, frame_tlp_s})};
        end else if (bus.tx_tlp_ready_i) begin
            out_valid_r <= 1'b0;
        end
    end

    // DLLP input is accepted every cycle once out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    assign bus.tlp_data_ready_o = tlp_ready_s;
    assign bus.tx_tlp_data_o    = out_data_r;
    assign bus.tx_tlp_valid_o   = out_valid_r;
    assign bus.dllp_ready_o     = run_r;
    assign bus.replay_active_o  = (state_r == ST_REPLAY);

endmodule

// File: tb/tb_urp_pcie_tx_data_link_layer.sv
// Self-checking bench: frame scoreboard, vector table and hand-written replay scenarios.
module tb_urp_pcie_tx_data_link_layer;
    import urp_pcie_dll_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [223:0] tlp;
        logic [11:0]  seq;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [267:0] sb_q[$];
    int           hs_cyc_q[$];
    logic [223:0] pay_mem [4096];
    logic [267:0] mon_exp;
    vec_t         vecs [8];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    urp_pcie_tx_data_link_layer_if bus();

    urp_pcie_tx_data_link_layer #(
        .DEPTH          (DEPTH),
        .REPLAY_TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference LCRC by polynomial long division of the seed-adjusted, 32-bit augmented message.
    function automatic logic [31:0] ref_lcrc(input logic [235:0] d);
        logic [267:0] m;
        m = {d, 32'h0};
        m[267:236] = m[267:236] ^ 32'hFFFF_FFFF;
        for (int i = 267; i >= 32; i--) begin
            if (m[i]) m[i -: 33] = m[i -: 33] ^ {1'b1, 32'h04C1_1DB7};
        end
        return ~m[31:0];
    endfunction

    function automatic logic [267:0] mk_frame(input logic [11:0] s, input logic [223:0] p);
        return {s, p, ref_lcrc({s, p})};
    endfunction

    task automatic check(input string name, input logic [267:0] act, input logic [267:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every frame handed to the link must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && bus.tx_tlp_valid_o && bus.tx_tlp_ready_i) begin
            hs_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got %0h expected none", bus.tx_tlp_data_o);
            end else begin
                mon_exp = sb_q.pop_front();
                check("frame", bus.tx_tlp_data_o, mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.tlp_data_valid_i = 1'b0;
        bus.dllp_valid_i     = 1'b0;
        bus.tx_tlp_ready_i   = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_tlp(input logic [223:0] p, input logic [11:0] s);
        bit ok;
        ok = 1'b0;
        bus.tlp_data_i       = p;
        bus.tlp_data_valid_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tlp_data_ready_o) begin
                sb_q.push_back(mk_frame(s, p));
                pay_mem[s] = p;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        bus.tlp_data_valid_i = 1'b0;
        check("tlp_accept", {267'd0, ok}, 268'd1);
    endtask

    task automatic send_dllp(input logic [7:0] t, input logic [11:0] s);
        bus.dllp_i       = {t, 12'h000, s};
        bus.dllp_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.dllp_valid_i = 1'b0;
    endtask

    task automatic push_replay(input logic [11:0] from_s, input logic [11:0] to_s);
        for (logic [11:0] s = from_s; s != to_s; s = s + 12'd1) sb_q.push_back(mk_frame(s, pay_mem[s]));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check(name, 268'(sb_q.size()), 268'd0);
    endtask

    initial begin
        int           acc0, ra_cyc, fr_cyc, ra_cnt;
        logic [223:0] p;
        bus.tlp_data_i       = 224'd0;
        bus.tlp_data_valid_i = 1'b0;
        bus.tx_tlp_ready_i   = 1'b1;
        bus.dllp_i           = 32'd0;
        bus.dllp_valid_i     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vecs[i].tlp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].seq = 12'(i);
        end

        // Reset values
        @(negedge clk);
        check("rst_valid", 268'(bus.tx_tlp_valid_o), 268'd0);
        check("rst_tlp_ready", 268'(bus.tlp_data_ready_o), 268'd0);
        check("rst_dllp_ready", 268'(bus.dllp_ready_o), 268'd0);
        check("rst_replay", 268'(bus.replay_active_o), 268'd0);
        do_reset();
        @(negedge clk);
        check("run_dllp_ready", 268'(bus.dllp_ready_o), 268'd1);
        check("run_tlp_ready", 268'(bus.tlp_data_ready_o), 268'd1);
        @(posedge clk);
        #1;

        // Single TLP, then ACK 0
        send_tlp(224'h1234, 12'd0);
        check("latency_valid", 268'(bus.tx_tlp_valid_o), 268'd1);
        send_dllp(DLLP_ACK, 12'd0);
        for (int i = 0; i < 3; i++) begin
            check("ack0_occupancy", 268'(dut.occupancy_s), 268'd0);
            check("ack0_timer", 268'(dut.timer_r), 268'd0);
            @(posedge clk);
            #1;
        end
        wait_drain("single_drain");

        // Fill the replay buffer from the vector table
        do_reset();
        for (int i = 0; i < 8; i++) send_tlp(vecs[i].tlp, vecs[i].seq);
        p = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        bus.tlp_data_i       = p;
        bus.tlp_data_valid_i = 1'b1;
        @(negedge clk);
        check("full_ready", 268'(bus.tlp_data_ready_o), 268'd0);
        bus.dllp_i       = {DLLP_ACK, 12'h000, 12'd3};
        bus.dllp_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.dllp_valid_i = 1'b0;
        @(negedge clk);
        check("ready_after_ack", 268'(bus.tlp_data_ready_o), 268'd1);
        if (bus.tlp_data_ready_o) begin
            sb_q.push_back(mk_frame(12'd8, p));
            pay_mem[8] = p;
        end
        @(posedge clk);
        #1 bus.tlp_data_valid_i = 1'b0;
        send_dllp(DLLP_ACK, 12'd8);
        check("full_purge_occ", 268'(dut.occupancy_s), 268'd0);
        wait_drain("full_drain");

        // NAK 1 after seq 0..4: replay 2,3,4 back-to-back
        do_reset();
        for (int i = 0; i < 5; i++) send_tlp({$urandom(), $urandom(), 160'd0, $urandom()}, 12'(i));
        wait_drain("nak_pre_drain");
        push_replay(12'd2, 12'd5);
        hs_cyc_q.delete();
        send_dllp(DLLP_NAK, 12'd1);
        check("nak_purge_occ", 268'(dut.occupancy_s), 268'd3);
        ra_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.replay_active_o) ra_cnt++;
        end
        check("nak_replay_cycles", 268'(ra_cnt), 268'd3);
        check("nak_replay_count", 268'(hs_cyc_q.size()), 268'd3);
        if (hs_cyc_q.size() == 3) check("nak_back_to_back", 268'(hs_cyc_q[2] - hs_cyc_q[0]), 268'd2);
        @(posedge clk);
        #1;
        wait_drain("nak_drain");
        send_dllp(DLLP_ACK, 12'd4);

        // Timeout replay of seq 0,1
        do_reset();
        send_tlp(224'hA0, 12'd0);
        acc0 = cyc;
        send_tlp(224'hA1, 12'd1);
        push_replay(12'd0, 12'd2);
        ra_cyc = -1;
        fr_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.replay_active_o && ra_cyc < 0) ra_cyc = cyc;
            if (bus.tx_tlp_valid_o && ra_cyc >= 0) begin
                fr_cyc = cyc;
                break;
            end
        end
        check("timeout_replay_start", 268'(ra_cyc - acc0), 268'd16);
        check("timeout_first_frame", 268'(fr_cyc - acc0), 268'd17);
        @(posedge clk);
        #1;
        wait_drain("timeout_drain");
        send_dllp(DLLP_ACK, 12'd1);

        // Sequence number wrap
        do_reset();
        for (int i = 0; i < 4094; i++) begin
            send_tlp({200'd0, 24'(i)}, 12'(i));
            if ((i % 4) == 3 || i == 4093) send_dllp(DLLP_ACK, 12'(i));
        end
        send_tlp(224'hE0, 12'd4094);
        send_tlp(224'hE1, 12'd4095);
        send_tlp(224'hE2, 12'd0);
        send_dllp(DLLP_ACK, 12'd0);
        check("wrap_acked", 268'(dut.acked_seq_r), 268'd0);
        check("wrap_occ", 268'(dut.occupancy_s), 268'd0);
        send_tlp(224'hE3, 12'd1);
        send_dllp(DLLP_ACK, 12'd4000);
        check("stale_acked", 268'(dut.acked_seq_r), 268'd0);
        check("stale_occ", 268'(dut.occupancy_s), 268'd1);
        send_dllp(DLLP_ACK, 12'd1);
        wait_drain("wrap_drain");

        // NAK while a frame is stalled on the link
        do_reset();
        for (int i = 0; i < 3; i++) send_tlp({$urandom(), 192'd0}, 12'(i));
        wait_drain("stall_pre_drain");
        bus.tx_tlp_ready_i = 1'b0;
        p = {$urandom(), $urandom(), 128'd7, $urandom()};
        send_tlp(p, 12'd3);
        send_dllp(DLLP_NAK, 12'd1);
        push_replay(12'd2, 12'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", 268'(bus.tx_tlp_valid_o), 268'd1);
            check("stall_frame", bus.tx_tlp_data_o, mk_frame(12'd3, p));
            check("stall_replay", 268'(bus.replay_active_o), 268'd1);
        end
        @(posedge clk);
        #1 bus.tx_tlp_ready_i = 1'b1;
        wait_drain("stall_drain");
        send_dllp(DLLP_ACK, 12'd3);
        check("stall_final_occ", 268'(dut.occupancy_s), 268'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/urp_pcie_tx_data_link_layer.md
# urp_pcie_tx_data_link_layer

Transmit-side data link layer. Takes 224-bit TLPs from the TX transaction layer, adds a 12-bit sequence number and a 32-bit LCRC, and sends 268-bit frames to the link, which uses the same framing as the RX path. Each sent frame is kept in a replay buffer until it is acknowledged. The block consumes the 32-bit ACK/NAK DLLPs generated by the RX data link layer: an ACK purges the buffer, and a NAK or a timeout replays it.

## Interface
- DEPTH, 8: replay buffer entries; power of 2, 2..2048.
- REPLAY_TIMEOUT, 1024: cycles without forward progress before a timeout replay.
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- tlp_data_i  in  224  TLP from the transaction layer.
- tlp_data_valid_i  in  1  TLP valid.
- tlp_data_ready_o  out  1  TLP accepted when valid & ready.
- tx_tlp_data_o  out  268  frame: [267:256] seq, [255:32] TLP, [31:0] LCRC over [267:32].
- tx_tlp_valid_o  out  1  frame valid.
- tx_tlp_ready_i  in  1  link ready.
- dllp_i  in  32  DLLP: [31:24] type (8'h00 ACK, 8'h10 NAK), [11:0] seq; other bits ignored.
- dllp_valid_i  in  1  DLLP valid.
- dllp_ready_o  out  1  tied 1 outside reset; one DLLP consumed per cycle.
- replay_active_o  out  1  high while in the REPLAY state.

## Operation
- State: next_seq (12b, reset 0), acked_seq (12b, reset 12'hFFF), occupancy = (next_seq - acked_seq - 1) mod 4096, replay pointer rp, timer, output frame register.
- FSM NORMAL:
  - tlp_data_ready_o = (occupancy < DEPTH) & (output register empty, or being drained this cycle).
  - On accept: build the frame with seq = next_seq and write the TLP to buffer[next_seq[log2(DEPTH)-1:0]].
  - Load the frame into the output register; next_seq increments, wrapping 4095 -> 0.
- ACK with seq s:
  - Valid only if d = (s - acked_seq) mod 4096 is in 1..occupancy. If valid, acked_seq <= s, which purges d entries, and the timer clears.
  - Otherwise the ACK is discarded with no state change. This covers duplicates and stale values.
- NAK with seq s:
  - Apply the ACK rule for s.
  - Then go to REPLAY with rp = s+1, even if s was a duplicate.
  - If occupancy after the purge is 0, stay in NORMAL.
- Timer:
  - Counts in NORMAL while occupancy > 0.
  - Clears on a valid ACK/NAK or when occupancy = 0.
  - At count == REPLAY_TIMEOUT-1: go to REPLAY with rp = acked_seq+1, and clear the timer.
- FSM REPLAY:
  - tlp_data_ready_o = 0.
  - Send buffered frames from rp up to next_seq-1 in order, with unchanged seq numbers and a recomputed LCRC. Return to NORMAL after the last frame is handed to the output register.
  - A valid ACK during replay purges; if acked_seq+1 is past rp, rp jumps to acked_seq+1.
  - A NAK during replay restarts with rp = s+1.
  - Timer held at 0.
- Output register:
  - Once valid, the frame is held stable until tx_tlp_ready_i; valid never drops without a handshake.
  - A NAK or timeout while a frame is pending does not cancel it; replay frames follow after it.
- Simultaneous DLLP and TLP accept in one cycle: both apply. Acceptance uses the registered occupancy, so a purge frees space from the next cycle.
- LCRC: CRC-32, polynomial 0x04C11DB7, init 32'hFFFFFFFF, final inversion, over the 236 bits [267:32] MSB-first. Single-cycle combinational.

## Timing
- Reset values:
  - All outputs 0 (dllp_ready_o 0 during reset, 1 after).
  - State NORMAL, next_seq 0, acked_seq 12'hFFF, timer 0, buffer contents don't-care.
- Latency: TLP accepted in cycle N -> tx_tlp_valid_o in N+1. Back-to-back throughput is 1 frame/cycle when tx_tlp_ready_i = 1.
- DLLP in cycle N -> acked_seq/state updated at N+1. The first replay frame is valid at N+2 if the output register is free.
- Reset asserted mid-operation: everything returns immediately to reset values; buffered frames are lost.

## Structure
- Package urp_pcie_dll_pkg:
  - DLLP type constants and frame field offsets.
  - Sequence width (12).
  - The function crc32_lcrc(236-bit) -> 32-bit, shared with the RX data link layer check.
- One sub-module, urp_pcie_replay_buffer: simple dual-port DEPTH x 224 RAM, registered write, combinational read.

## Test plan
- Single TLP 224'h1234 with ready=1:
  - Frame at +1 cycle: seq 0, correct LCRC.
  - ACK seq 0 -> occupancy 0, and the timer stays 0.
- Send 8 TLPs with DEPTH=8 and no ACK: the 9th sees tlp_data_ready_o = 0. ACK seq 3 -> ready rises the next cycle.
- Send seq 0..4, then NAK seq 1:
  - Purges 0..1.
  - Replays 2,3,4 back-to-back with identical payloads.
  - replay_active_o high for the 3 frames, then NORMAL.
- No ACK after seq 0..1 with REPLAY_TIMEOUT=16: replay of seq 0,1 starts, with the first frame at cycle 16+1 after the last timer clear.
- Sequence wrap:
  - Preload next_seq to 4094 via traffic; frames carry 4094, 4095, 0.
  - ACK 0 purges all three.
  - A stale ACK 4000 is ignored.
- NAK arrives while tx_tlp_ready_i = 0 with a frame pending: the pending frame stays unchanged until ready, then the replay frames follow.
